cla_rr_add_sched: RTL and testbench

//  Round-robin scheduler sharing one registered WIDTH-bit carry-lookahead add stage among NREQ requesters.

---
 rtl/cla_rr_add_sched.sv | 216 +++++++++++++++++++++
 tb/tb_cla_rr_add_sched.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_rr_add_sched.sv
// Round-robin scheduler in front of one shared, registered carry-lookahead adder.
// Requesters present operand beats on valid/ready streams; the winner's beat is
// captured into an OP register, summed by a 4-bit-group CLA and registered into
// RES together with the requester ID. A locked burst keeps the grant so that
// multi-word adds can chain the carry of the previous beat.
module cla_rr_add_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  input  logic [NREQ-1:0]       req_lock,
  input  logic [NREQ-1:0]       req_chain,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_sum,
  output logic                  res_cout,
  output logic [IDW-1:0]        res_id
);

  localparam int NGRP = WIDTH / 4;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t           state_reg, state_next;
  logic [IDW-1:0]   ptr_reg, ptr_next;
  logic [IDW-1:0]   owner_reg, owner_next;

  // OP stage
  logic             op_valid_reg;
  logic [WIDTH-1:0] op_a_reg, op_b_reg;
  logic             op_cin_reg, op_chain_reg;
  logic [IDW-1:0]   op_id_reg;

  // RES stage
  logic             res_valid_reg;
  logic [WIDTH-1:0] res_sum_reg;
  logic             res_cout_reg;
  logic [IDW-1:0]   res_id_reg;

  // Handshake / arbitration
  logic             res_load, op_open, accept;
  logic             grant_found;
  logic [IDW-1:0]   grant_id;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_cin, sel_lock, sel_chain;

  // Adder
  logic             op_cin_eff;
  logic [WIDTH-1:0] bit_g, bit_p, bit_c, cla_sum;
  logic [NGRP:0]    grp_c;
  logic             cla_cout;

  // RES refills when empty or drained; OP can take a beat when empty or moving on.
  assign res_load = !res_valid_reg || res_ready;
  assign op_open  = !op_valid_reg || res_load;
  assign accept   = grant_found && op_open;

  // Pick the winner: the locked owner, or the first valid requester at/after ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    if (state_reg == ST_LOCKED) begin
      grant_found = req_valid[owner_reg];
      grant_id    = owner_reg;
    end else begin
      // Lower-priority half (below ptr) first, so the upper half overrides it.
      for (int j = NREQ - 1; j >= 0; j--) begin
        if (req_valid[j] && (j < int'(ptr_reg))) begin
          grant_found = 1'b1;
          grant_id    = IDW'(j);
        end
      end
      for (int j = NREQ - 1; j >= 0; j--) begin
        if (req_valid[j] && (j >= int'(ptr_reg))) begin
          grant_found = 1'b1;
          grant_id    = IDW'(j);
        end
      end
    end
  end

  // Route the winner's operands and control bits.
  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_cin   = 1'b0;
    sel_lock  = 1'b0;
    sel_chain = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (int'(grant_id) == k) begin
        sel_a     = req_a[k*WIDTH +: WIDTH];
        sel_b     = req_b[k*WIDTH +: WIDTH];
        sel_cin   = req_cin[k];
        sel_lock  = req_lock[k];
        // A chain request only means something inside an open burst.
        sel_chain = req_chain[k] && (state_reg == ST_LOCKED);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = accept && (int'(grant_id) == gi);
    end
  endgenerate

  // Burst lock and round-robin pointer update on each accepted beat.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    if (accept) begin
      if (sel_lock) begin
        state_next = ST_LOCKED;
        owner_next = grant_id;
      end else begin
        state_next = ST_IDLE;
        ptr_next   = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
    end
  end

  // OP register: capture the accepted beat, or empty out when it advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_valid_reg <= 1'b0;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      op_cin_reg   <= 1'b0;
      op_chain_reg <= 1'b0;
      op_id_reg    <= '0;
    end else if (op_open) begin
      op_valid_reg <= accept;
      if (accept) begin
        op_a_reg     <= sel_a;
        op_b_reg     <= sel_b;
        op_cin_reg   <= sel_cin;
        op_chain_reg <= sel_chain;
        op_id_reg    <= grant_id;
      end
    end
  end

  // Chained beats take the carry of the last beat loaded into RES; res_cout is
  // kept across bubbles so it still holds that carry.
  assign op_cin_eff = op_chain_reg ? res_cout_reg : op_cin_reg;

  assign bit_g    = op_a_reg & op_b_reg;
  assign bit_p    = op_a_reg ^ op_b_reg;
  assign grp_c[0] = op_cin_eff;

  generate
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_cla
      localparam int B = gi * 4;
      logic grp_g, grp_p;
      assign bit_c[B]   = grp_c[gi];
      assign bit_c[B+1] = bit_g[B] | (bit_p[B] & grp_c[gi]);
      assign bit_c[B+2] = bit_g[B+1] | (bit_p[B+1] & bit_g[B])
                        | (bit_p[B+1] & bit_p[B] & grp_c[gi]);
      assign bit_c[B+3] = bit_g[B+2] | (bit_p[B+2] & bit_g[B+1])
                        | (bit_p[B+2] & bit_p[B+1] & bit_g[B])
                        | (bit_p[B+2] & bit_p[B+1] & bit_p[B] & grp_c[gi]);
      assign grp_g = bit_g[B+3] | (bit_p[B+3] & bit_g[B+2])
                   | (bit_p[B+3] & bit_p[B+2] & bit_g[B+1])
                   | (bit_p[B+3] & bit_p[B+2] & bit_p[B+1] & bit_g[B]);
      assign grp_p = &bit_p[B +: 4];
      assign grp_c[gi+1] = grp_g | (grp_p & grp_c[gi]);
    end
  endgenerate

  assign cla_sum  = bit_p ^ bit_c;
  assign cla_cout = grp_c[NGRP];

  // RES register: take the OP beat's sum whenever RES is free to load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid_reg <= 1'b0;
      res_sum_reg   <= '0;
      res_cout_reg  <= 1'b0;
      res_id_reg    <= '0;
    end else if (res_load) begin
      res_valid_reg <= op_valid_reg;
      if (op_valid_reg) begin
        res_sum_reg  <= cla_sum;
        res_cout_reg <= cla_cout;
        res_id_reg   <= op_id_reg;
      end
    end
  end

  assign res_valid = res_valid_reg;
  assign res_sum   = res_sum_reg;
  assign res_cout  = res_cout_reg;
  assign res_id    = res_id_reg;

endmodule

// File: tb/tb_cla_rr_add_sched.sv
// Directed bench for cla_rr_add_sched: reset, fairness, latency/overflow,
// locked multi-word bursts, backpressure and pointer wrap.
module tb_cla_rr_add_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 64;
  localparam int IDW   = 2;
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic [NREQ-1:0]       req_lock;
  logic [NREQ-1:0]       req_chain;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_sum;
  logic                  res_cout;
  logic [IDW-1:0]        res_id;

  int checks   = 0;
  int failures = 0;

  cla_rr_add_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_lock  (req_lock),
    .req_chain (req_chain),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_id    (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic cin,
                         input logic lock, input logic chain);
    req_valid[i]              = v;
    req_a[i*WIDTH +: WIDTH]   = a;
    req_b[i*WIDTH +: WIDTH]   = b;
    req_cin[i]                = cin;
    req_lock[i]               = lock;
    req_chain[i]              = chain;
  endtask

  task automatic test_reset();
    rst = 1'b0; res_ready = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; req_lock = '0; req_chain = '0;
    #3;
    checks++; if ({res_valid, res_cout, res_id, res_sum} !== '0) begin failures++;
      $display("FAIL reset_outputs got v=%b c=%b id=%0d sum=%h exp all 0", res_valid, res_cout, res_id, res_sum); end
    checks++; if (req_ready !== 4'b0000) begin failures++;
      $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    tick();
    rst = 1'b1;
    set_req(0, 1'b1, 64'd3, 64'd4, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin failures++;
      $display("FAIL reset_first_rdy got=%b exp=0001", req_ready); end
    @(negedge clk);
    @(negedge clk);
    checks++; if ({res_valid, res_id, res_cout, res_sum} !== {1'b1, 2'd0, 1'b0, 64'd7}) begin failures++;
      $display("FAIL reset_pre_res got v=%b id=%0d c=%b sum=%h exp v=1 id=0 c=0 sum=7", res_valid, res_id, res_cout, res_sum); end
    #1;
    rst = 1'b0;
    set_req(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if ({res_valid, res_sum} !== {1'b0, 64'd0}) begin failures++;
      $display("FAIL reset_async got v=%b sum=%h exp v=0 sum=0", res_valid, res_sum); end
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (res_valid !== 1'b0) begin failures++;
        $display("FAIL reset_stale k=%0d got v=%b exp 0", k, res_valid); end
    end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0]  exp_rdy;
    logic [IDW-1:0]   eid;
    logic [WIDTH-1:0] esum;
    tick();
    res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 64'(100 * (i + 1)), 64'(i), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      exp_rdy = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
      checks++; if (req_ready !== exp_rdy) begin failures++;
        $display("FAIL fair_rdy k=%0d got=%b exp=%b", k, req_ready, exp_rdy); end
      if (k >= 2 && k <= 9) begin
        eid  = IDW'((k - 2) % 4);
        esum = 64'(100 * ((k - 2) % 4 + 1) + (k - 2) % 4);
        $display("fair res k=%0d v=%b id=%0d sum=%0d", k, res_valid, res_id, res_sum);
        checks++; if ({res_valid, res_id, res_cout, res_sum} !== {1'b1, eid, 1'b0, esum}) begin failures++;
          $display("FAIL fair_res k=%0d got v=%b id=%0d sum=%0d exp v=1 id=%0d sum=%0d", k, res_valid, res_id, res_sum, eid, esum); end
      end else begin
        checks++; if (res_valid !== 1'b0) begin failures++;
          $display("FAIL fair_idle k=%0d got v=%b exp 0", k, res_valid); end
      end
      if (k == 7) begin
        tick();
        for (int i = 0; i < NREQ; i++) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic test_latency();
    tick();
    set_req(0, 1'b1, ONES, 64'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin failures++;
      $display("FAIL lat_rdy got=%b exp=0001", req_ready); end
    tick();
    set_req(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin failures++;
      $display("FAIL lat_early got v=%b exp 0", res_valid); end
    @(negedge clk);
    $display("lat res v=%b id=%0d cout=%b sum=%h", res_valid, res_id, res_cout, res_sum);
    checks++; if ({res_valid, res_id, res_cout, res_sum} !== {1'b1, 2'd0, 1'b1, 64'd0}) begin failures++;
      $display("FAIL lat_res got v=%b id=%0d c=%b sum=%h exp v=1 id=0 c=1 sum=0", res_valid, res_id, res_cout, res_sum); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin failures++;
      $display("FAIL lat_after got v=%b exp 0", res_valid); end
  endtask

  task automatic test_multiword();
    // c0: low word of the req2 burst
    tick();
    set_req(2, 1'b1, ONES, 64'd1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin failures++;
      $display("FAIL mw_rdy0 got=%b exp=0100", req_ready); end
    // c1: middle word, competing req1 appears
    tick();
    set_req(2, 1'b1, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1);
    set_req(1, 1'b1, 64'd5, 64'd6, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin failures++;
      $display("FAIL mw_rdy1 got=%b exp=0100", req_ready); end
    // c2: owner idle, lock must still block req1
    tick();
    set_req(2, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin failures++;
      $display("FAIL mw_gap_rdy got=%b exp=0000", req_ready); end
    checks++; if ({res_valid, res_id, res_cout, res_sum} !== {1'b1, 2'd2, 1'b1, 64'd0}) begin failures++;
      $display("FAIL mw_res0 got v=%b id=%0d c=%b sum=%h exp v=1 id=2 c=1 sum=0", res_valid, res_id, res_cout, res_sum); end
    // c3: last word ends the burst
    tick();
    set_req(2, 1'b1, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin failures++;
      $display("FAIL mw_rdy3 got=%b exp=0100", req_ready); end
    checks++; if ({res_valid, res_id, res_cout, res_sum} !== {1'b1, 2'd2, 1'b0, 64'd1}) begin failures++;
      $display("FAIL mw_res1 got v=%b id=%0d c=%b sum=%h exp v=1 id=2 c=0 sum=1", res_valid, res_id, res_cout, res_sum); end
    // c4: req1 granted right after the burst
    tick();
    set_req(2, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin failures++;
      $display("FAIL mw_rdy_req1 got=%b exp=0010", req_ready); end
    tick();
    set_req(1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if ({res_valid, res_id, res_cout, res_sum} !== {1'b1, 2'd2, 1'b0, 64'd0}) begin failures++;
      $display("FAIL mw_res2 got v=%b id=%0d c=%b sum=%h exp v=1 id=2 c=0 sum=0", res_valid, res_id, res_cout, res_sum); end
    tick();
    @(negedge clk);
    checks++; if ({res_valid, res_id, res_cout, res_sum} !== {1'b1, 2'd1, 1'b0, 64'd12}) begin failures++;
      $display("FAIL mw_res_req1 got v=%b id=%0d c=%b sum=%0d exp v=1 id=1 c=0 sum=12", res_valid, res_id, res_cout, res_sum); end
    tick();
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin failures++;
      $display("FAIL mw_drain got v=%b exp 0", res_valid); end
  endtask

  task automatic test_backpressure();
    // ptr is 2 here: req3 wins first, then req0, then req1
    tick();
    res_ready = 1'b0;
    set_req(0, 1'b1, 64'd10, 64'd20, 1'b0, 1'b0, 1'b0);
    set_req(1, 1'b1, 64'd7, 64'd8, 1'b1, 1'b0, 1'b0);
    set_req(3, 1'b1, ONES, ONES, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (req_ready !== 4'b1000) begin failures++;
      $display("FAIL bp_rdy0 got=%b exp=1000", req_ready); end
    tick();
    req_valid[3] = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin failures++;
      $display("FAIL bp_rdy1 got=%b exp=0001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (req_ready !== 4'b0000) begin failures++;
        $display("FAIL bp_hold_rdy k=%0d got=%b exp=0000", k, req_ready); end
      checks++; if ({res_valid, res_id, res_cout, res_sum} !== {1'b1, 2'd3, 1'b1, ONES}) begin failures++;
        $display("FAIL bp_hold_res k=%0d got v=%b id=%0d c=%b sum=%h exp v=1 id=3 c=1 sum=all ones", k, res_valid, res_id, res_cout, res_sum); end
      if (k < 4) tick();
    end
    tick();
    res_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin failures++;
      $display("FAIL bp_release_rdy got=%b exp=0010", req_ready); end
    checks++; if ({res_valid, res_id} !== {1'b1, 2'd3}) begin failures++;
      $display("FAIL bp_release_res got v=%b id=%0d exp v=1 id=3", res_valid, res_id); end
    tick();
    req_valid[1] = 1'b0;
    @(negedge clk);
    checks++; if ({res_valid, res_id, res_cout, res_sum} !== {1'b1, 2'd0, 1'b0, 64'd30}) begin failures++;
      $display("FAIL bp_res_req0 got v=%b id=%0d c=%b sum=%0d exp v=1 id=0 c=0 sum=30", res_valid, res_id, res_cout, res_sum); end
    tick();
    @(negedge clk);
    checks++; if ({res_valid, res_id, res_cout, res_sum} !== {1'b1, 2'd1, 1'b0, 64'd16}) begin failures++;
      $display("FAIL bp_res_req1 got v=%b id=%0d c=%b sum=%0d exp v=1 id=1 c=0 sum=16", res_valid, res_id, res_cout, res_sum); end
    tick();
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin failures++;
      $display("FAIL bp_drain got v=%b exp 0 (duplicate)", res_valid); end
  endtask

  task automatic test_wrap();
    // single req2 beat moves ptr to 3
    tick();
    set_req(2, 1'b1, 64'd1, 64'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin failures++;
      $display("FAIL wrap_setup_rdy got=%b exp=0100", req_ready); end
    tick();
    req_valid[2] = 1'b0;
    set_req(0, 1'b1, 64'd4, 64'd4, 1'b0, 1'b0, 1'b0);
    set_req(3, 1'b1, 64'd9, 64'd9, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (req_ready !== 4'b1000) begin failures++;
      $display("FAIL wrap_rdy3 got=%b exp=1000", req_ready); end
    tick();
    req_valid[3] = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin failures++;
      $display("FAIL wrap_rdy0 got=%b exp=0001", req_ready); end
    checks++; if ({res_valid, res_id, res_sum} !== {1'b1, 2'd2, 64'd3}) begin failures++;
      $display("FAIL wrap_res2 got v=%b id=%0d sum=%0d exp v=1 id=2 sum=3", res_valid, res_id, res_sum); end
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    checks++; if ({res_valid, res_id, res_sum} !== {1'b1, 2'd3, 64'd18}) begin failures++;
      $display("FAIL wrap_res3 got v=%b id=%0d sum=%0d exp v=1 id=3 sum=18", res_valid, res_id, res_sum); end
    tick();
    @(negedge clk);
    checks++; if ({res_valid, res_id, res_sum} !== {1'b1, 2'd0, 64'd8}) begin failures++;
      $display("FAIL wrap_res0 got v=%b id=%0d sum=%0d exp v=1 id=0 sum=8", res_valid, res_id, res_sum); end
    tick();
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin failures++;
      $display("FAIL wrap_drain got v=%b exp 0", res_valid); end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_latency();
    test_multiword();
    test_backpressure();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
